gemm_operand_feeder: RTL and testbench



---
 rtl/gemm_operand_feeder.sv | 191 +++++++++++++++++++
 tb/tb_gemm_operand_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_operand_feeder.sv
// rtl/gemm_operand_feeder.sv - streams one A row / B column from operand SRAMs into vec_mac
module gemm_operand_feeder #(
  parameter int N          = 8,
  parameter int WIDTH      = 16,
  parameter int NUM_MACS   = 2,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [15:0]                           row_size,
  input  logic [ADDR_W-1:0]                     a_base,
  input  logic [ADDR_W-1:0]                     b_base,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  a_rd_en,
  output logic                                  b_rd_en,
  output logic [ADDR_W-1:0]                     a_rd_addr,
  output logic [ADDR_W-1:0]                     b_rd_addr,
  input  logic [NUM_MACS*N*WIDTH-1:0]           a_rd_data,
  input  logic [NUM_MACS*N*WIDTH-1:0]           b_rd_data,
  output logic [NUM_MACS-1:0][0:N-1][WIDTH-1:0] vector_A,
  output logic [NUM_MACS-1:0][0:N-1][WIDTH-1:0] vector_B,
  output logic                                  vec_valid,
  output logic                                  vec_last,
  input  logic                                  vec_ready
);

  localparam int L  = NUM_MACS * N;
  localparam int DW = L * WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [15:0]       r_row_size;
  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_b_base;
  logic [15:0]       r_beats;
  logic [15:0]       r_issue;
  logic              r_inflight;
  logic [15:0]       r_cap_idx;
  logic [DW-1:0]     r_fifo_a [FIFO_DEPTH];
  logic [DW-1:0]     r_fifo_b [FIFO_DEPTH];
  logic              r_fifo_last [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_valid;
  logic              w_pop;
  logic [CW:0]       w_occ;
  logic              w_rd_en;
  logic [15:0]       w_start_beats;
  logic [31:0]       w_cap_base;
  logic [DW-1:0]     w_cap_a;
  logic [DW-1:0]     w_cap_b;
  logic              w_cap_last;
  logic [DW-1:0]     w_head_a;
  logic [DW-1:0]     w_head_b;
  logic              w_head_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid & vec_ready;
  // Entries already committed (buffered or in flight), less the one leaving this cycle
  assign w_occ         = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
  assign w_rd_en       = (r_state == S_RUN) && (r_issue < r_beats) && (w_occ < DEPTH_W);
  assign w_start_beats = 16'((32'(row_size) + 32'(L - 1)) / 32'(L));
  assign w_cap_base    = 32'(r_cap_idx) * 32'(L);
  assign w_cap_last    = (r_cap_idx == r_beats - 16'd1);
  assign w_head_a      = r_fifo_a[r_rd_ptr];
  assign w_head_b      = r_fifo_b[r_rd_ptr];
  assign w_head_last   = r_fifo_last[r_rd_ptr];

  assign a_rd_en   = w_rd_en;
  assign b_rd_en   = w_rd_en;
  assign a_rd_addr = w_rd_en ? r_a_base + ADDR_W'(r_issue) : '0;
  assign b_rd_addr = w_rd_en ? r_b_base + ADDR_W'(r_issue) : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign vec_valid = w_valid;

  // Zero every lane past the end of the row in the beat being captured
  always_comb begin
    w_cap_a = a_rd_data;
    w_cap_b = b_rd_data;
    for (int k = 0; k < L; k++) begin
      if (w_cap_base + 32'(k) >= 32'(r_row_size)) begin
        w_cap_a[k*WIDTH +: WIDTH] = '0;
        w_cap_b[k*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // Present the head entry, remapping flat lane k to [k/N][k%N]; zeros when empty
  always_comb begin
    vector_A = '0;
    vector_B = '0;
    vec_last = 1'b0;
    if (w_valid) begin
      vec_last = w_head_last;
      for (int m = 0; m < NUM_MACS; m++) begin
        for (int i = 0; i < N; i++) begin
          vector_A[m][i] = w_head_a[(m*N+i)*WIDTH +: WIDTH];
          vector_B[m][i] = w_head_b[(m*N+i)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Control FSM: latch config on start, count issued reads, finish on the last handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_row_size <= '0;
      r_a_base   <= '0;
      r_b_base   <= '0;
      r_beats    <= '0;
      r_issue    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_size <= row_size;
            r_a_base   <= a_base;
            r_b_base   <= b_base;
            r_beats    <= w_start_beats;
            r_issue    <= '0;
            r_state    <= (row_size == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_rd_en) begin
            r_issue <= r_issue + 16'd1;
            if (r_issue + 16'd1 == r_beats) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Track the outstanding read and move captured beats through the buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
      r_cap_idx  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        r_fifo_a[e]    <= '0;
        r_fifo_b[e]    <= '0;
        r_fifo_last[e] <= 1'b0;
      end
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) r_cap_idx <= r_issue;
      if (r_inflight) begin
        r_fifo_a[r_wr_ptr]    <= w_cap_a;
        r_fifo_b[r_wr_ptr]    <= w_cap_b;
        r_fifo_last[r_wr_ptr] <= w_cap_last;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A capture into a full buffer with no pop would silently drop a beat
  always_ff @(posedge clk) begin
    if (rst && r_inflight && !w_pop) assert (r_count < DEPTH_C);
  end

endmodule

// File: tb/tb_gemm_operand_feeder.sv
// tb/tb_gemm_operand_feeder.sv - scoreboard bench for gemm_operand_feeder
module tb_gemm_operand_feeder;

  localparam int N          = 8;
  localparam int WIDTH      = 16;
  localparam int NUM_MACS   = 2;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 2;
  localparam int L          = NUM_MACS * N;
  localparam int DW         = L * WIDTH;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  typedef logic [NUM_MACS-1:0][0:N-1][WIDTH-1:0] vec_t;
  typedef logic [575:0] wide_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              vec_ready = 1'b0;
  logic [15:0]       row_size = '0;
  logic [ADDR_W-1:0] a_base = '0;
  logic [ADDR_W-1:0] b_base = '0;
  logic              busy, done, a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [DW-1:0]     a_rd_data = '0;
  logic [DW-1:0]     b_rd_data = '0;
  vec_t              vector_A, vector_B;
  logic              vec_valid, vec_last;

  logic [DW-1:0] mem_a [MEM_WORDS];
  logic [DW-1:0] mem_b [MEM_WORDS];

  vec_t exp_a [$];
  vec_t exp_b [$];
  bit   exp_last [$];
  int   s_cyc [$];
  int   s_aa [$];
  int   s_ba [$];
  int   hs_cyc [$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   outstanding = 0;
  int   max_out = 0;
  int   valid_cnt = 0;
  int   en_neq = 0;
  int   idle_nz = 0;
  logic busy1, busy_done;
  logic p_valid = 1'b0;
  logic p_ready = 1'b0;
  logic [2*NUM_MACS*N*WIDTH:0] p_data = '0;
  vec_t m_ea, m_eb;
  bit   m_el;
  int   dr;

  gemm_operand_feeder #(
    .N(N), .WIDTH(WIDTH), .NUM_MACS(NUM_MACS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .row_size(row_size),
    .a_base(a_base), .b_base(b_base), .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .vector_A(vector_A), .vector_B(vector_B),
    .vec_valid(vec_valid), .vec_last(vec_last), .vec_ready(vec_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM pair: one-cycle read latency, data holds until the next strobe
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  function automatic logic [WIDTH-1:0] lane_val(input int addr, input bit is_b, input int k);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(addr);
    return {(is_b ? 4'hB : 4'hA), a[7:0], 4'(k)};
  endfunction

  task automatic check_eq(input string tag, input wide_t got, input wide_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_row(input int rs, input int ab, input int bb);
    int nb;
    vec_t va, vb;
    nb = (rs + L - 1) / L;
    for (int j = 0; j < nb; j++) begin
      for (int m = 0; m < NUM_MACS; m++) begin
        for (int i = 0; i < N; i++) begin
          if (j * L + m * N + i < rs) begin
            va[m][i] = lane_val((ab + j) % MEM_WORDS, 1'b0, m * N + i);
            vb[m][i] = lane_val((bb + j) % MEM_WORDS, 1'b1, m * N + i);
          end else begin
            va[m][i] = '0;
            vb[m][i] = '0;
          end
        end
      end
      exp_a.push_back(va);
      exp_b.push_back(vb);
      exp_last.push_back(j == nb - 1);
    end
  endtask

  task automatic check_strobes(input int n, input int ab, input int bb);
    check_eq("strobe_count", s_aa.size(), n);
    for (int i = 0; i < n && i < s_aa.size(); i++) begin
      check_eq("strobe_a_addr", s_aa[i], (ab + i) % MEM_WORDS);
      check_eq("strobe_b_addr", s_ba[i], (bb + i) % MEM_WORDS);
    end
  endtask

  task automatic run_row(input int rs, input int ab, input int bb, input int lo, input int hi,
                         input int restart_rel, output int done_rel);
    int rel;
    bit seen;
    s_cyc.delete(); s_aa.delete(); s_ba.delete(); hs_cyc.delete();
    outstanding = 0; max_out = 0; valid_cnt = 0;
    @(posedge clk); #1;
    row_size = 16'(rs); a_base = ADDR_W'(ab); b_base = ADDR_W'(bb);
    start = 1'b1; vec_ready = 1'b1; t0 = cyc;
    push_row(rs, ab, bb);
    seen = 0; done_rel = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      start = (rel == restart_rel);
      if (rel == restart_rel) begin
        row_size = 16'd64; a_base = 10'h300; b_base = 10'h3F0;
      end
      vec_ready = !(rel >= lo && rel <= hi);
      @(negedge clk);
      if (rel == 1) busy1 = busy;
      if (done) begin
        seen = 1; done_rel = rel; busy_done = busy;
      end
    end
    if (!seen) check_eq("done_timeout", 0, 1);
    check_eq("sb_drained", exp_a.size(), 0);
  endtask

  task automatic check_after_done();
    @(negedge clk);
    check_eq("busy_after_done", busy, 0);
    check_eq("done_single_pulse", done, 0);
  endtask

  // Monitor: log strobes/handshakes, score beats, check stall stability and idle zeros
  always @(negedge clk) begin
    if (rst) begin
      if (vec_valid) valid_cnt++;
      if (vec_valid && vec_ready) begin
        hs_cyc.push_back(cyc - t0);
        outstanding--;
        if (exp_a.size() == 0) begin
          check_eq("extra_beat", 1, 0);
        end else begin
          m_ea = exp_a.pop_front();
          m_eb = exp_b.pop_front();
          m_el = exp_last.pop_front();
          check_eq("beat_A", vector_A, m_ea);
          check_eq("beat_B", vector_B, m_eb);
          check_eq("beat_last", vec_last, m_el);
        end
      end
      if (a_rd_en != b_rd_en) en_neq++;
      if (a_rd_en) begin
        s_cyc.push_back(cyc - t0);
        s_aa.push_back(int'(a_rd_addr));
        s_ba.push_back(int'(b_rd_addr));
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
      end
      if (p_valid && !p_ready)
        check_eq("hold_stable", {vec_valid, vec_last, vector_A, vector_B}, {1'b1, p_data});
      if (!vec_valid && (vector_A != '0 || vector_B != '0 || vec_last)) idle_nz++;
      p_valid = vec_valid;
      p_ready = vec_ready;
      p_data  = {vec_last, vector_A, vector_B};
    end else begin
      p_valid = 1'b0;
    end
  end

  initial begin
    for (int a = 0; a < MEM_WORDS; a++) begin
      for (int k = 0; k < L; k++) begin
        mem_a[a][k*WIDTH +: WIDTH] = lane_val(a, 1'b0, k);
        mem_b[a][k*WIDTH +: WIDTH] = lane_val(a, 1'b1, k);
      end
    end

    repeat (2) @(negedge clk);
    check_eq("reset_outputs",
             {busy, done, vec_valid, vec_last, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, vector_A, vector_B}, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Full-throughput row
    run_row(32, 5, 100, 1, 0, -1, dr);
    check_eq("t1_done_cycle", dr, 5);
    check_eq("t1_busy_cycle1", busy1, 1);
    check_eq("t1_busy_at_done", busy_done, 1);
    check_strobes(2, 5, 100);
    check_eq("t1_strobe_cycles", {s_cyc.size(), s_cyc[0], s_cyc[1]}, {32'd2, 32'd1, 32'd2});
    check_eq("t1_beat_cycles", {hs_cyc.size(), hs_cyc[0], hs_cyc[1]}, {32'd2, 32'd3, 32'd4});
    check_after_done();

    // Partial last beat
    run_row(20, 40, 200, 1, 0, -1, dr);
    check_eq("t2_done_cycle", dr, 5);
    check_eq("t2_beats", hs_cyc.size(), 2);
    check_after_done();

    // Back-pressure in cycles 3..6
    run_row(64, 20, 300, 3, 6, -1, dr);
    check_eq("t3_beats", hs_cyc.size(), 4);
    check_eq("t3_max_outstanding_le2", max_out <= 2, 1);
    check_strobes(4, 20, 300);
    check_eq("t3_beat_cycles", {hs_cyc[0], hs_cyc[1], hs_cyc[2], hs_cyc[3]},
             {32'd7, 32'd8, 32'd9, 32'd10});
    check_eq("t3_done_after_last_hs", dr, hs_cyc[hs_cyc.size()-1] + 1);
    check_eq("t3_done_cycle", dr, 11);
    check_after_done();

    // Zero length
    run_row(0, 0, 0, 1, 0, -1, dr);
    check_eq("t4_done_cycle", dr, 1);
    check_eq("t4_busy_cycle1", busy1, 1);
    check_eq("t4_no_strobes", s_aa.size(), 0);
    check_eq("t4_no_valid", valid_cnt, 0);
    check_after_done();

    // Second start during a busy row is ignored
    run_row(32, 50, 60, 1, 0, 2, dr);
    check_eq("t4b_done_cycle", dr, 5);
    check_eq("t4b_beats", hs_cyc.size(), 2);
    check_strobes(2, 50, 60);
    check_after_done();

    // Address wrap
    run_row(48, 1023, 7, 1, 0, -1, dr);
    check_eq("t5_done_cycle", dr, 6);
    check_strobes(3, 1023, 7);
    check_after_done();

    // Mid-row reset asserted in cycle 3
    @(posedge clk); #1;
    row_size = 16'd48; a_base = 10'd500; b_base = 10'd600; start = 1'b1; vec_ready = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("midrst_outputs",
             {busy, done, vec_valid, vec_last, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, vector_A, vector_B}, '0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_idle", {busy, vec_valid, a_rd_en}, 0);
    @(negedge clk);
    check_eq("midrst_data_discarded", {busy, vec_valid}, 0);
    exp_a.delete(); exp_b.delete(); exp_last.delete();

    run_row(16, 2, 3, 1, 0, -1, dr);
    check_eq("t6_done_cycle", dr, 4);
    check_eq("t6_beats", hs_cyc.size(), 1);
    check_strobes(1, 2, 3);
    check_after_done();

    check_eq("rd_en_equal", en_neq, 0);
    check_eq("idle_vectors_zero", idle_nz, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
